pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage MIPS pipeline. Drives the write/flush controls of PC, IF/ID, ID/EX and EX/MEM.

---
 rtl/pipe_ctrl_pkg.sv | 17 +
 rtl/sat_counter.sv | 23 ++
 rtl/pipeline_hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared encodings for the pipeline hazard controller
package pipe_ctrl_pkg;

   // Controller FSM states; values are visible on state_o for debug.
   typedef enum logic [1:0] {
      ST_RUN       = 2'd0,
      ST_FLUSH     = 2'd1,
      ST_MULT_WAIT = 2'd2
   } state_t;

   // Default register-index width of the MIPS register file.
   localparam int REG_W_DEF = 5;

   // Encoding of the bubble written into IF/ID on a flush (sll $0,$0,0).
   localparam logic [31:0] NOP_INSN = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up counter with synchronous clear
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   // Clear beats increment; increment sticks at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != {W{1'b1}})) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_W        = REG_W_DEF,
   parameter int FLUSH_CYCLES = 1,
   parameter int MULT_LATENCY = 4,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rt,
   input  logic [REG_W-1:0] ex_rt,
   input  logic             ex_mem_read,
   input  logic             branch_taken,
   input  logic             mult_start,
   input  logic             dmem_busy,
   input  logic             stall_cnt_clr,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_write,
   output logic             idex_flush,
   output logic             exmem_write,
   output logic             exmem_flush,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 2);
   localparam logic [2:0] MULT_RELOAD  = 3'(MULT_LATENCY - 2);
   localparam bit         FLUSH_MULTI  = (FLUSH_CYCLES > 1);
   localparam bit         MULT_STALLS  = (MULT_LATENCY >= 2);

   state_t     state, state_nxt;
   logic [2:0] cnt, cnt_nxt;
   logic       load_use;

   // Load in EX writes a register the ID instruction is about to read ($0 never hazards).
   always_comb begin
      load_use = ex_mem_read && (ex_rt != '0) &&
                 ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
   end

   // State and sub-cycle counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_RUN;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state and same-cycle pipeline controls; dmem_busy freezes everything.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_write  = 1'b1;
      idex_flush  = 1'b0;
      exmem_write = 1'b1;
      exmem_flush = 1'b0;

      if (!rst_n) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         ifid_flush  = 1'b1;
         idex_write  = 1'b0;
         idex_flush  = 1'b1;
         exmem_write = 1'b0;
      end else if (dmem_busy) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_write  = 1'b0;
         exmem_write = 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               if (load_use) begin
                  pc_write   = 1'b0;
                  ifid_write = 1'b0;
                  idex_flush = 1'b1;
               end else if (branch_taken) begin
                  ifid_flush = 1'b1;
                  if (FLUSH_MULTI) begin
                     state_nxt = ST_FLUSH;
                     cnt_nxt   = FLUSH_RELOAD;
                  end
               end else if (mult_start && MULT_STALLS) begin
                  pc_write    = 1'b0;
                  ifid_write  = 1'b0;
                  idex_write  = 1'b0;
                  exmem_flush = 1'b1;
                  state_nxt   = ST_MULT_WAIT;
                  cnt_nxt     = MULT_RELOAD;
               end
            end
            ST_FLUSH: begin
               ifid_flush = 1'b1;
               if (cnt == 3'd0) begin
                  state_nxt = ST_RUN;
               end else begin
                  cnt_nxt = cnt - 3'd1;
               end
            end
            ST_MULT_WAIT: begin
               if (cnt != 3'd0) begin
                  pc_write    = 1'b0;
                  ifid_write  = 1'b0;
                  idex_write  = 1'b0;
                  exmem_flush = 1'b1;
                  cnt_nxt     = cnt - 3'd1;
               end else begin
                  state_nxt = ST_RUN;
               end
            end
            default: begin
               state_nxt = ST_RUN;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   // Debug view of the FSM.
   always_comb begin
      state_o = state;
   end

   sat_counter #(
      .W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (stall_cnt_clr),
      .inc   (!pc_write),
      .cnt   (stall_cnt)
   );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] id_rs, id_rt, ex_rt;
   logic       id_uses_rt, ex_mem_read, branch_taken, mult_start, dmem_busy, stall_cnt_clr;
   logic       pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, exmem_flush;
   logic [1:0] state_o;
   logic [15:0] stall_cnt;

   logic       pc_write2, ifid_write2, ifid_flush2, idex_write2, idex_flush2, exmem_write2, exmem_flush2;
   logic [1:0] state_o2;
   logic [1:0] stall_cnt2;

   int total = 0;
   int bad   = 0;

   // Output vector order: {pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, exmem_f}
   localparam logic [6:0] O_DEF = 7'b1101010;
   localparam logic [6:0] O_LU  = 7'b0001110;
   localparam logic [6:0] O_BR  = 7'b1111010;
   localparam logic [6:0] O_MS  = 7'b0000011;
   localparam logic [6:0] O_FZ  = 7'b0000000;
   localparam logic [6:0] O_RST = 7'b0010100;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(
      .REG_W(5), .FLUSH_CYCLES(2), .MULT_LATENCY(4), .CNT_W(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_rt(ex_rt), .ex_mem_read(ex_mem_read), .branch_taken(branch_taken),
      .mult_start(mult_start), .dmem_busy(dmem_busy), .stall_cnt_clr(stall_cnt_clr),
      .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
      .idex_write(idex_write), .idex_flush(idex_flush), .exmem_write(exmem_write),
      .exmem_flush(exmem_flush), .state_o(state_o), .stall_cnt(stall_cnt)
   );

   pipeline_hazard_ctrl #(
      .REG_W(5), .FLUSH_CYCLES(2), .MULT_LATENCY(4), .CNT_W(2)
   ) dut_sat (
      .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_rt(ex_rt), .ex_mem_read(ex_mem_read), .branch_taken(branch_taken),
      .mult_start(mult_start), .dmem_busy(dmem_busy), .stall_cnt_clr(stall_cnt_clr),
      .pc_write(pc_write2), .ifid_write(ifid_write2), .ifid_flush(ifid_flush2),
      .idex_write(idex_write2), .idex_flush(idex_flush2), .exmem_write(exmem_write2),
      .exmem_flush(exmem_flush2), .state_o(state_o2), .stall_cnt(stall_cnt2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_step(input string tag, input logic [6:0] eo, input logic [1:0] es);
      chk({tag, ".outs"}, 32'({pc_write, ifid_write, ifid_flush, idex_write,
                               idex_flush, exmem_write, exmem_flush}), 32'(eo));
      chk({tag, ".state"}, 32'(state_o), 32'(es));
   endtask

   task automatic idle_inputs();
      id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0; id_uses_rt = 1'b0;
      ex_mem_read = 1'b0; branch_taken = 1'b0; mult_start = 1'b0;
      dmem_busy = 1'b0; stall_cnt_clr = 1'b0;
   endtask

   // Inputs change just after a falling edge; checks sample 1 time unit later.
   task automatic next_cycle();
      @(negedge clk);
   endtask

   initial begin
      idle_inputs();
      rst_n = 1'b0;
      #1;
      chk_step("reset", O_RST, 2'd0);
      chk("reset.cnt", 32'(stall_cnt), 32'd0);
      next_cycle();
      next_cycle();
      rst_n = 1'b1;
      #1;
      chk_step("idle", O_DEF, 2'd0);
      next_cycle();

      // Load-use on rs
      ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; #1;
      chk_step("lu_rs", O_LU, 2'd0);
      next_cycle();
      idle_inputs(); #1;
      chk_step("lu_after", O_DEF, 2'd0);
      chk("lu_cnt", 32'(stall_cnt), 32'd1);
      next_cycle();

      // rt match only counts when ID actually reads rt
      ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd3; id_rt = 5'd8; #1;
      chk_step("rt_unused", O_DEF, 2'd0);
      id_uses_rt = 1'b1; #1;
      chk_step("rt_used", O_LU, 2'd0);
      next_cycle();
      idle_inputs(); #1;
      chk("rt_cnt", 32'(stall_cnt), 32'd2);

      // Taken branch: two flush cycles, PC keeps advancing
      next_cycle();
      branch_taken = 1'b1; #1;
      chk_step("br0", O_BR, 2'd0);
      next_cycle();
      branch_taken = 1'b0; #1;
      chk_step("br1", O_BR, 2'd1);
      next_cycle(); #1;
      chk_step("br_done", O_DEF, 2'd0);
      next_cycle();

      // Multiply: three stall cycles then a release cycle
      mult_start = 1'b1; #1;
      chk_step("mul0", O_MS, 2'd0);
      next_cycle(); #1;
      chk_step("mul1", O_MS, 2'd2);
      next_cycle(); #1;
      chk_step("mul2", O_MS, 2'd2);
      next_cycle(); #1;
      chk_step("mul_rel", O_DEF, 2'd2);
      next_cycle();
      mult_start = 1'b0; #1;
      chk_step("mul_done", O_DEF, 2'd0);
      chk("mul_cnt", 32'(stall_cnt), 32'd5);
      chk("sat_cnt", 32'(stall_cnt2), 32'd3);
      next_cycle();

      // Multiply with a two-cycle memory freeze at cnt=1
      mult_start = 1'b1; #1;
      chk_step("mfz0", O_MS, 2'd0);
      next_cycle(); #1;
      chk_step("mfz1", O_MS, 2'd2);
      next_cycle();
      dmem_busy = 1'b1; #1;
      chk_step("mfz_busy0", O_FZ, 2'd2);
      next_cycle(); #1;
      chk_step("mfz_busy1", O_FZ, 2'd2);
      next_cycle();
      dmem_busy = 1'b0; #1;
      chk_step("mfz2", O_MS, 2'd2);
      next_cycle(); #1;
      chk_step("mfz_rel", O_DEF, 2'd2);
      next_cycle();
      mult_start = 1'b0; #1;
      chk_step("mfz_done", O_DEF, 2'd0);
      chk("mfz_cnt", 32'(stall_cnt), 32'd10);

      // Load-use and branch together: stall first, branch flushes next cycle
      ex_mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd9; branch_taken = 1'b1; #1;
      chk_step("lubr0", O_LU, 2'd0);
      next_cycle();
      ex_mem_read = 1'b0; #1;
      chk_step("lubr1", O_BR, 2'd0);
      next_cycle();
      branch_taken = 1'b0; #1;
      chk_step("lubr2", O_BR, 2'd1);
      next_cycle(); #1;
      chk_step("lubr_done", O_DEF, 2'd0);
      chk("lubr_cnt", 32'(stall_cnt), 32'd11);

      // Clear beats a simultaneous increment
      ex_mem_read = 1'b1; ex_rt = 5'd4; id_rs = 5'd4; stall_cnt_clr = 1'b1; #1;
      chk_step("clr_lu", O_LU, 2'd0);
      next_cycle();
      idle_inputs(); #1;
      chk("clr_cnt", 32'(stall_cnt), 32'd0);
      next_cycle();

      // Reset asserted in the middle of FLUSH
      branch_taken = 1'b1;
      next_cycle();
      branch_taken = 1'b0; #1;
      chk_step("pre_rst", O_BR, 2'd1);
      rst_n = 1'b0; #1;
      chk_step("mid_rst", O_RST, 2'd0);
      chk("mid_rst_cnt", 32'(stall_cnt), 32'd0);
      next_cycle();
      rst_n = 1'b1;

      // A load to $0 never causes a stall
      ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1; #1;
      chk_step("lu_zero", O_DEF, 2'd0);
      next_cycle();
      idle_inputs(); #1;
      chk("final_cnt", 32'(stall_cnt), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
